// File: rtl/apb_master_bridge.sv
// AHB-Lite to APB bridge for six peripherals (uart0, timer, wdog, dual timer,
// uart1, spi) selected by HADDR[15:12]; unmapped regions get a two-cycle ERROR.
// Optional macro APB_TIMEOUT_EN adds an ACCESS-phase timeout that ends a
// stalled transfer with an ERROR response after TIMEOUT_CYCLES cycles.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [5:0]  PSEL,
  output logic [11:0] PADDR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic [31:0] PRDATA
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} stateType;

  stateType    state;
  stateType    launchState;
  logic        accept;
  logic        takeNew;
  logic        complete;
  logic        slaveError;
  logic        timeoutHit;
  logic        mapped;
  logic [5:0]  launchSel;
  logic        unusedBits;

  // Byte lanes and the SEQ/NONSEQ distinction do not matter to the APB side.
  assign unusedBits = ^{HADDR[1:0], HTRANS[0], 8'(TIMEOUT_CYCLES)};

  // Write data passes straight through; AHB holds it during the data phase.
  assign PWDATA = HWDATA;

`ifdef APB_TIMEOUT_EN
  logic [7:0] waitCount;

  assign timeoutHit = (state == ACCESS) && !PREADY &&
                      (waitCount == 8'(TIMEOUT_CYCLES - 1));

  // Count stalled ACCESS cycles; any exit from ACCESS starts the count afresh.
  always_ff @(posedge HCLK) begin
    if (HRESET)
      waitCount <= 8'd0;
    else if (state == ACCESS && !PREADY && !timeoutHit)
      waitCount <= waitCount + 8'd1;
    else
      waitCount <= 8'd0;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Bus-facing handshake, error flag, read data and the decode of a new transfer.
  always_comb begin
    complete    = (state == ACCESS) && PREADY && !PSLVERR;
    slaveError  = (state == ACCESS) && PREADY && PSLVERR;
    mapped      = (HADDR[15:12] <= 4'd5);
    launchSel   = mapped ? (6'b000001 << HADDR[14:12]) : 6'b000000;
    launchState = mapped ? SETUP : ERR1;
    accept      = HSEL && HTRANS[1] && HREADY;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = 32'd0;
    case (state)
      IDLE:    HREADYOUT = 1'b1;
      SETUP:   HREADYOUT = 1'b0;
      ACCESS:  HREADYOUT = complete;
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: HREADYOUT = 1'b1;
    endcase
    if (complete && !PWRITE)
      HRDATA = PRDATA;
    takeNew = accept && HREADYOUT;
  end

  // Transfer sequencer with registered APB control outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= IDLE;
      PSEL    <= 6'b000000;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 12'd0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          if (takeNew) begin
            state   <= launchState;
            PSEL    <= launchSel;
            PENABLE <= 1'b0;
            PADDR   <= {HADDR[11:2], 2'b00};
            PWRITE  <= HWRITE;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (complete) begin
            PENABLE <= 1'b0;
            if (takeNew) begin
              state  <= launchState;
              PSEL   <= launchSel;
              PADDR  <= {HADDR[11:2], 2'b00};
              PWRITE <= HWRITE;
            end else begin
              state <= IDLE;
              PSEL  <= 6'b000000;
            end
          end else if (slaveError || timeoutHit) begin
            state   <= ERR1;
            PSEL    <= 6'b000000;
            PENABLE <= 1'b0;
          end
        end
        ERR1: state <= ERR2;
        default: begin
          state   <= IDLE;
          PSEL    <= 6'b000000;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge.
module tb_apb_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [5:0]  PSEL;
  logic [11:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  // Free-running bus clock.
  always #5 HCLK = ~HCLK;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [15:0] addr,
                               input logic [1:0] trans, input logic write,
                               input logic ready, input logic [31:0] wdata,
                               input logic pready, input logic pslverr,
                               input logic [31:0] prdata);
    HSEL    = sel;
    HADDR   = addr;
    HTRANS  = trans;
    HWRITE  = write;
    HREADY  = ready;
    HWDATA  = wdata;
    PREADY  = pready;
    PSLVERR = pslverr;
    PRDATA  = prdata;
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic readyOut,
                             input logic resp, input logic [31:0] rdata,
                             input logic [5:0] sel, input logic enable);
    checkValue({tag, ".HREADYOUT"}, 32'(HREADYOUT), 32'(readyOut));
    checkValue({tag, ".HRESP"},     32'(HRESP),     32'(resp));
    checkValue({tag, ".HRDATA"},    HRDATA,         rdata);
    checkValue({tag, ".PSEL"},      32'(PSEL),      32'(sel));
    checkValue({tag, ".PENABLE"},   32'(PENABLE),   32'(enable));
  endtask

  // Directed sequence covering each bridge scenario in turn.
  initial begin
    HRESET = 1'b1;
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    tick();
    tick();
    checkOutput("reset", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);
    checkValue("reset.PWRITE", 32'(PWRITE), 32'h0);
    checkValue("reset.PADDR", 32'(PADDR), 32'h0);
    HRESET = 1'b0;
    #1;

    // Zero-wait write to timer
    applyStimulus(1'b1, 16'h1004, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    checkOutput("wr.idle", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hDEADBEEF);
    checkOutput("wr.setup", 1'b0, 1'b0, 32'h0, 6'b000010, 1'b0);
    checkValue("wr.setup.PADDR", 32'(PADDR), 32'h004);
    checkValue("wr.setup.PWRITE", 32'(PWRITE), 32'h1);
    checkValue("wr.setup.PWDATA", PWDATA, 32'hA5A5A5A5);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF);
    checkOutput("wr.access", 1'b1, 1'b0, 32'h0, 6'b000010, 1'b1);
    checkValue("wr.access.PWDATA", PWDATA, 32'hA5A5A5A5);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wr.done", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);

    // Read from spi with three wait states; ignored accept attempts during waits
    applyStimulus(1'b1, 16'h5008, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 16'h0000, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rd.setup", 1'b0, 1'b0, 32'h0, 6'b100000, 1'b0);
    checkValue("rd.setup.PADDR", 32'(PADDR), 32'h008);
    checkValue("rd.setup.PWRITE", 32'(PWRITE), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b1, 16'h0000, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h12345678);
      checkOutput($sformatf("rd.wait%0d", i), 1'b0, 1'b0, 32'h0, 6'b100000, 1'b1);
    end
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h12345678);
    checkOutput("rd.done", 1'b1, 1'b0, 32'h12345678, 6'b100000, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h12345678);
    checkOutput("rd.idle", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);

    // Slave error from wdog
    applyStimulus(1'b1, 16'h2000, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("slverr.setup", 1'b0, 1'b0, 32'h0, 6'b000100, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h55AA55AA);
    checkOutput("slverr.access", 1'b0, 1'b0, 32'h0, 6'b000100, 1'b1);
    tick();
    applyStimulus(1'b1, 16'h1000, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("slverr.err1", 1'b0, 1'b1, 32'h0, 6'b000000, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("slverr.err2", 1'b1, 1'b1, 32'h0, 6'b000000, 1'b0);
    tick();
    checkOutput("slverr.idle", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);

    // Unmapped region, then a new transfer accepted in ERR2
    applyStimulus(1'b1, 16'h7000, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("unmap.err1", 1'b0, 1'b1, 32'h0, 6'b000000, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h4010, 2'b11, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("unmap.err2", 1'b1, 1'b1, 32'h0, 6'b000000, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h11112222, 1'b0, 1'b0, 32'h0);
    checkOutput("err2new.setup", 1'b0, 1'b0, 32'h0, 6'b010000, 1'b0);
    checkValue("err2new.PADDR", 32'(PADDR), 32'h010);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h11112222, 1'b1, 1'b0, 32'h0);
    checkOutput("err2new.access", 1'b1, 1'b0, 32'h0, 6'b010000, 1'b1);
    tick();

    // Back-to-back writes: uart0 then dual timer
    applyStimulus(1'b1, 16'h0000, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b.setup1", 1'b0, 1'b0, 32'h0, 6'b000001, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h3000, 2'b10, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 32'h0);
    checkOutput("b2b.access1", 1'b1, 1'b0, 32'h0, 6'b000001, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b.setup2", 1'b0, 1'b0, 32'h0, 6'b001000, 1'b0);
    checkValue("b2b.setup2.PADDR", 32'(PADDR), 32'h000);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 32'h0);
    checkOutput("b2b.access2", 1'b1, 1'b0, 32'h0, 6'b001000, 1'b1);
    tick();
    checkOutput("b2b.idle", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);

    // Reset in the middle of a stalled ACCESS
    applyStimulus(1'b1, 16'h1000, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rst.access", 1'b0, 1'b0, 32'h0, 6'b000010, 1'b1);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    #1;
    checkOutput("rst.after", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);

    // Stuck PREADY on the timer
    applyStimulus(1'b1, 16'h1000, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      checkValue($sformatf("stuck.access%0d.PENABLE", i), 32'(PENABLE), 32'h1);
      tick();
    end
`ifdef APB_TIMEOUT_EN
    checkOutput("timeout.err1", 1'b0, 1'b1, 32'h0, 6'b000000, 1'b0);
    tick();
    checkOutput("timeout.err2", 1'b1, 1'b1, 32'h0, 6'b000000, 1'b0);
    tick();
`else
    checkOutput("stuck.still", 1'b0, 1'b0, 32'h0, 6'b000010, 1'b1);
    applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0BADF00D);
    checkOutput("stuck.release", 1'b1, 1'b0, 32'h0BADF00D, 6'b000010, 1'b1);
    tick();
`endif
    checkOutput("final.idle", 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
